enemy_unit: RTL and testbench
=============================

Name: enemy_unit

Overview:
Single enemy sprite for the invader grid. Holds its own position, hit points and alive state. Moves one pixel per frame tick in the direction commanded by the grid controller. Renders itself against the VGA scan position (DrawX, DrawY). The grid instantiates 21 copies: the easy variant uses KIND=0 and the medium variant uses KIND=1. Per-copy colour and RGB outputs are ORed/summed by the parent, so inactive copies must output zero.

Parameters:
KIND, 0, enemy type: 0 = easy (1 hit point), 1 = medium (2 hit points)
WIDTH, 50, sprite bounding-box width in pixels
HEIGHT, 44, sprite bounding-box height in pixels

Ports:
Clk  in  1  system clock; all state updates on rising edge
Reset  in  1  synchronous, active-low reset
frame_clk  in  1  frame tick level, sampled on Clk; its rising edge (previous sample 0, current 1) forms a one-cycle move strobe
delete_enemies  in  1  level; forces the enemy dead (game over or wave cleared)
hit  in  1  collision pulse from projectile logic, coincident with the scan pixel
is_playing  in  1  game running; movement enabled only when high
enemy_direction_X  in  1  1 = move right (+1), 0 = move left (-1)
enemy_direction_Y  in  1  1 = also move down (+1) this tick, 0 = no vertical move
enemy_initial_x  in  10  spawn X (left edge of the box)
enemy_initial_y  in  10  spawn Y (top edge of the box)
DrawX, DrawY  in  10 each  current scan pixel
start  in  1  game start or restart request
enemy_on  out  1  current pixel belongs to this live enemy
enemy_R, enemy_G, enemy_B  out  8 each  pixel colour; all zero when enemy_on=0

Behaviour:
- State machine: IDLE, ACTIVE, DEAD.
- Reset (Reset=0 at a Clk edge):
  - state=IDLE, X=enemy_initial_x, Y=enemy_initial_y, hp = (KIND ? 2 : 1).
  - frame edge detector cleared to 0.
- IDLE: sprite is visible at the spawn position and does not move. start=1 -> ACTIVE on the next edge.
- ACTIVE: on a move strobe with is_playing=1:
  - X <= X + 1 if enemy_direction_X=1, else X - 1.
  - Y <= Y + 1 if enemy_direction_Y=1, else Y unchanged.
  - Arithmetic is 10-bit modulo 1024, with no clamping; edge detection is the parent's job.
- Hit acceptance:
  - Applies when hit=1 AND enemy_on=1 in the same cycle AND state=ACTIVE.
  - On acceptance, hp decrements; at hp 1 -> 0 the state goes to DEAD.
  - A hit held for several cycles counts once per cycle in which the acceptance conditions hold.
- delete_enemies=1 in any state -> DEAD on the next edge. It has priority over start, hit and move.
- DEAD: enemy_on=0 and RGB=0. start=1 with delete_enemies=0 reloads the spawn position and full hp and goes to ACTIVE.
- start while ACTIVE: same reload, state stays ACTIVE.
- Rendering is combinational from registered state:
  - The box spans DrawX in [X, X+WIDTH-1] and DrawY in [Y, Y+HEIGHT-1]; compute with 11-bit sums so the box does not wrap.
  - The box is divided into a 10x11 grid of 5x4-pixel cells: col = (DrawX-X)/5, row = (DrawY-Y)/4.
  - Mask excludes corner cells (col 0 or 9) AND (row 0, 1, 9 or 10).
  - enemy_on = (state != DEAD) AND inside box AND mask bit.
  - Eye cells (row 3, col 3) and (row 3, col 6) are on, coloured 0x00/0x00/0x00.
- Body colours:
  - Easy: 0x00/0xFF/0x00.
  - Medium with hp=2: 0xFF/0x00/0xFF.
  - Medium with hp=1 (damaged): 0xFF/0x80/0x00.

Test Plan:
- Reset with init (73, 50), KIND=0 -> at DrawX=80, DrawY=60: enemy_on=1, RGB=00/FF/00. At DrawX=73, DrawY=50 (corner cell) and at DrawX=123: enemy_on=0, RGB=0.
- IDLE, three frame ticks -> X stays 73. start pulse, then 3 ticks with is_playing=1, dir_X=1, dir_Y=0 -> X=76, Y=50. One tick with dir_X=0, dir_Y=1 -> X=75, Y=51. Ticks with is_playing=0 -> no motion.
- KIND=1, ACTIVE: hit=1 for one cycle while DrawX/DrawY inside the body -> hp=1 and colour FF/80/00. Second such hit -> DEAD, enemy_on=0 everywhere.
- hit=1 while scan pixel is outside the box -> no change. hit in IDLE -> no change.
- delete_enemies=1 together with start and hit -> DEAD. Then start with delete_enemies=0 -> back at spawn, full hp, ACTIVE.
- frame_clk held high for 100 Clk cycles -> exactly one move. Reset=0 mid-ACTIVE -> IDLE at spawn on the next edge.

Source files
------------

// File: rtl/enemy_unit.sv
// One invader sprite: holds position, hit points and life state, moves on frame ticks,
// and draws itself against the VGA scan position. The parent ORs/sums every copy's outputs.
module enemy_unit #(
    parameter int KIND   = 0,
    parameter int WIDTH  = 50,
    parameter int HEIGHT = 44
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       delete_enemies,
    input  logic       hit,
    input  logic       is_playing,
    input  logic       enemy_direction_X,
    input  logic       enemy_direction_Y,
    input  logic [9:0] enemy_initial_x,
    input  logic [9:0] enemy_initial_y,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       start,
    output logic       enemy_on,
    output logic [7:0] enemy_R,
    output logic [7:0] enemy_G,
    output logic [7:0] enemy_B
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DEAD   = 2'd2;

    localparam logic [1:0] HP_FULL = (KIND != 0) ? 2'd2 : 2'd1;

    logic [1:0] state_q, state_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [1:0] hp_q, hp_d;
    logic       frame_prev_q, frame_prev_d;

    logic [10:0] box_right;
    logic [10:0] box_bottom;
    logic        in_x;
    logic        in_y;
    logic [9:0]  off_x;
    logic [9:0]  off_y;
    logic [9:0]  col;
    logic [9:0]  row;
    logic        corner;
    logic        eye;
    logic        move_strobe;
    logic        hit_accept;

    // Box edges use 11-bit sums so a sprite near the right/bottom edge never wraps to 0.
    always_comb begin
        box_right  = {1'b0, x_q} + 11'(WIDTH);
        box_bottom = {1'b0, y_q} + 11'(HEIGHT);
        in_x       = ({1'b0, DrawX} >= {1'b0, x_q}) && ({1'b0, DrawX} < box_right);
        in_y       = ({1'b0, DrawY} >= {1'b0, y_q}) && ({1'b0, DrawY} < box_bottom);
        off_x      = DrawX - x_q;
        off_y      = DrawY - y_q;
        col        = off_x / 10'd5;
        row        = off_y / 10'd4;
        corner     = ((col == 10'd0) || (col == 10'd9)) &&
                     ((row == 10'd0) || (row == 10'd1) || (row == 10'd9) || (row == 10'd10));
        eye        = (row == 10'd3) && ((col == 10'd3) || (col == 10'd6));
        enemy_on   = (state_q != ST_DEAD) && in_x && in_y && !corner;
    end

    // Eye cells are part of the sprite but stay black; everything off-sprite is zero.
    always_comb begin
        enemy_R = 8'h00;
        enemy_G = 8'h00;
        enemy_B = 8'h00;
        if (enemy_on && !eye) begin
            if (KIND == 0) begin
                enemy_G = 8'hFF;
            end else if (hp_q == 2'd2) begin
                enemy_R = 8'hFF;
                enemy_B = 8'hFF;
            end else begin
                enemy_R = 8'hFF;
                enemy_G = 8'h80;
            end
        end
    end

    assign move_strobe = frame_clk && !frame_prev_q;
    assign hit_accept  = hit && enemy_on && (state_q == ST_ACTIVE);

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        hp_d         = hp_q;
        frame_prev_d = frame_clk;
        if (delete_enemies) begin
            state_d = ST_DEAD;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        x_d     = enemy_initial_x;
                        y_d     = enemy_initial_y;
                        hp_d    = HP_FULL;
                        state_d = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (start) begin
                        x_d  = enemy_initial_x;
                        y_d  = enemy_initial_y;
                        hp_d = HP_FULL;
                    end else begin
                        if (move_strobe && is_playing) begin
                            x_d = enemy_direction_X ? (x_q + 10'd1) : (x_q - 10'd1);
                            if (enemy_direction_Y) begin
                                y_d = y_q + 10'd1;
                            end
                        end
                        if (hit_accept) begin
                            hp_d = hp_q - 2'd1;
                            if (hp_q == 2'd1) begin
                                state_d = ST_DEAD;
                            end
                        end
                    end
                end
                ST_DEAD: begin
                    if (start) begin
                        x_d     = enemy_initial_x;
                        y_d     = enemy_initial_y;
                        hp_d    = HP_FULL;
                        state_d = ST_ACTIVE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            x_q          <= enemy_initial_x;
            y_q          <= enemy_initial_y;
            hp_q         <= HP_FULL;
            frame_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            hp_q         <= hp_d;
            frame_prev_q <= frame_prev_d;
        end
    end

endmodule

// File: tb/tb_enemy_unit.sv
// Bench for enemy_unit: an easy (KIND=0) and a medium (KIND=1) copy share the scan and motion
// inputs; expected pixel colours are queued with each probe and compared when the probe is sampled.
module tb_enemy_unit;

    localparam logic [23:0] GREEN   = 24'h00FF00;
    localparam logic [23:0] MAGENTA = 24'hFF00FF;
    localparam logic [23:0] ORANGE  = 24'hFF8000;
    localparam logic [23:0] BLACK   = 24'h000000;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic       is_playing;
    logic       dir_x;
    logic       dir_y;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       start_e, start_m;
    logic       hit_e, hit_m;
    logic       del_e, del_m;
    logic [9:0] init_x_e, init_y_e, init_x_m, init_y_m;
    logic       on_e, on_m;
    logic [7:0] r_e, g_e, b_e, r_m, g_m, b_m;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          unit;
        logic [9:0]  px;
        logic [9:0]  py;
        logic [24:0] exp;
        string       name;
    } probe_t;

    probe_t sb_q[$];

    always #5 Clk = ~Clk;

    enemy_unit #(.KIND(0), .WIDTH(50), .HEIGHT(44)) dut_e (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .delete_enemies(del_e), .hit(hit_e),
        .is_playing(is_playing), .enemy_direction_X(dir_x), .enemy_direction_Y(dir_y),
        .enemy_initial_x(init_x_e), .enemy_initial_y(init_y_e), .DrawX(DrawX), .DrawY(DrawY),
        .start(start_e), .enemy_on(on_e), .enemy_R(r_e), .enemy_G(g_e), .enemy_B(b_e)
    );

    enemy_unit #(.KIND(1), .WIDTH(50), .HEIGHT(44)) dut_m (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .delete_enemies(del_m), .hit(hit_m),
        .is_playing(is_playing), .enemy_direction_X(dir_x), .enemy_direction_Y(dir_y),
        .enemy_initial_x(init_x_m), .enemy_initial_y(init_y_m), .DrawX(DrawX), .DrawY(DrawY),
        .start(start_m), .enemy_on(on_m), .enemy_R(r_m), .enemy_G(g_m), .enemy_B(b_m)
    );

    function automatic logic [24:0] observe(input int unit);
        if (unit == 0) return {on_e, r_e, g_e, b_e};
        return {on_m, r_m, g_m, b_m};
    endfunction

    task automatic push_probe(input int unit, input int px, input int py, input logic on,
                              input logic [23:0] rgb, input string name);
        probe_t p;
        p.unit = unit;
        p.px   = 10'(px);
        p.py   = 10'(py);
        p.exp  = on ? {1'b1, rgb} : 25'd0;
        p.name = name;
        sb_q.push_back(p);
    endtask

    // Column 0 rows 2..8 and row 0 column 1 are body cells, so these four probes pin X and Y exactly.
    task automatic push_pos(input int unit, input int x, input int y, input logic [23:0] rgb,
                            input string name);
        push_probe(unit, x,     y + 8, 1'b1, rgb,   {name, "_left_in"});
        push_probe(unit, x - 1, y + 8, 1'b0, BLACK, {name, "_left_out"});
        push_probe(unit, x + 5, y,     1'b1, rgb,   {name, "_top_in"});
        push_probe(unit, x + 5, y - 1, 1'b0, BLACK, {name, "_top_out"});
    endtask

    task automatic frame_tick();
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
    endtask

    task automatic test_reset();
        probe_t p;
        logic [24:0] got;
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        push_probe(0, 80, 60, 1'b1, GREEN, "easy_body");
        push_probe(0, 73, 50, 1'b0, BLACK, "easy_corner");
        push_probe(0, 123, 60, 1'b0, BLACK, "easy_past_right");
        push_probe(0, 88, 62, 1'b1, BLACK, "easy_eye");
        push_probe(1, 207, 310, 1'b1, MAGENTA, "medium_body");
        push_pos(0, 73, 50, GREEN, "easy_spawn");
        while (sb_q.size() > 0) begin
            p = sb_q.pop_front();
            @(negedge Clk);
            DrawX = p.px;
            DrawY = p.py;
            #1;
            got = observe(p.unit);
            checks++;
            if (got !== p.exp) begin
                errors++;
                $display("[TB] FAIL %s: got on/rgb=%0b/%06h, expected %0b/%06h",
                         p.name, got[24], got[23:0], p.exp[24], p.exp[23:0]);
            end
        end
    endtask

    task automatic test_idle_hit();
        probe_t p;
        logic [24:0] got;
        @(negedge Clk);
        DrawX = 10'd207;
        DrawY = 10'd310;
        hit_m = 1'b1;
        @(negedge Clk) hit_m = 1'b0;
        push_probe(1, 207, 310, 1'b1, MAGENTA, "idle_hit_ignored");
        while (sb_q.size() > 0) begin
            p = sb_q.pop_front();
            @(negedge Clk);
            DrawX = p.px;
            DrawY = p.py;
            #1;
            got = observe(p.unit);
            checks++;
            if (got !== p.exp) begin
                errors++;
                $display("[TB] FAIL %s: got on/rgb=%0b/%06h, expected %0b/%06h",
                         p.name, got[24], got[23:0], p.exp[24], p.exp[23:0]);
            end
        end
    endtask

    task automatic test_move();
        probe_t p;
        logic [24:0] got;
        is_playing = 1'b1;
        dir_x = 1'b1;
        dir_y = 1'b0;
        repeat (3) frame_tick();
        push_pos(0, 73, 50, GREEN, "idle_no_move");
        while (sb_q.size() > 0) begin
            p = sb_q.pop_front();
            @(negedge Clk);
            DrawX = p.px;
            DrawY = p.py;
            #1;
            got = observe(p.unit);
            checks++;
            if (got !== p.exp) begin
                errors++;
                $display("[TB] FAIL %s: got on/rgb=%0b/%06h, expected %0b/%06h",
                         p.name, got[24], got[23:0], p.exp[24], p.exp[23:0]);
            end
        end
        @(negedge Clk) start_e = 1'b1;
        @(negedge Clk) start_e = 1'b0;
        repeat (3) frame_tick();
        push_pos(0, 76, 50, GREEN, "move_right3");
        while (sb_q.size() > 0) begin
            p = sb_q.pop_front();
            @(negedge Clk);
            DrawX = p.px;
            DrawY = p.py;
            #1;
            got = observe(p.unit);
            checks++;
            if (got !== p.exp) begin
                errors++;
                $display("[TB] FAIL %s: got on/rgb=%0b/%06h, expected %0b/%06h",
                         p.name, got[24], got[23:0], p.exp[24], p.exp[23:0]);
            end
        end
        dir_x = 1'b0;
        dir_y = 1'b1;
        frame_tick();
        is_playing = 1'b0;
        repeat (2) frame_tick();
        push_pos(0, 75, 51, GREEN, "move_left_down");
        push_pos(1, 200, 300, MAGENTA, "medium_idle_still");
        while (sb_q.size() > 0) begin
            p = sb_q.pop_front();
            @(negedge Clk);
            DrawX = p.px;
            DrawY = p.py;
            #1;
            got = observe(p.unit);
            checks++;
            if (got !== p.exp) begin
                errors++;
                $display("[TB] FAIL %s: got on/rgb=%0b/%06h, expected %0b/%06h",
                         p.name, got[24], got[23:0], p.exp[24], p.exp[23:0]);
            end
        end
    endtask

    task automatic test_hit_medium();
        probe_t p;
        logic [24:0] got;
        @(negedge Clk) start_m = 1'b1;
        @(negedge Clk) start_m = 1'b0;
        DrawX = 10'd199;
        DrawY = 10'd310;
        hit_m = 1'b1;
        @(negedge Clk) hit_m = 1'b0;
        push_probe(1, 207, 310, 1'b1, MAGENTA, "hit_outside_ignored");
        while (sb_q.size() > 0) begin
            p = sb_q.pop_front();
            @(negedge Clk);
            DrawX = p.px;
            DrawY = p.py;
            #1;
            got = observe(p.unit);
            checks++;
            if (got !== p.exp) begin
                errors++;
                $display("[TB] FAIL %s: got on/rgb=%0b/%06h, expected %0b/%06h",
                         p.name, got[24], got[23:0], p.exp[24], p.exp[23:0]);
            end
        end
        @(negedge Clk);
        DrawX = 10'd207;
        DrawY = 10'd310;
        hit_m = 1'b1;
        @(negedge Clk) hit_m = 1'b0;
        push_probe(1, 207, 310, 1'b1, ORANGE, "medium_damaged");
        push_probe(1, 218, 312, 1'b1, BLACK, "medium_eye");
        while (sb_q.size() > 0) begin
            p = sb_q.pop_front();
            @(negedge Clk);
            DrawX = p.px;
            DrawY = p.py;
            #1;
            got = observe(p.unit);
            checks++;
            if (got !== p.exp) begin
                errors++;
                $display("[TB] FAIL %s: got on/rgb=%0b/%06h, expected %0b/%06h",
                         p.name, got[24], got[23:0], p.exp[24], p.exp[23:0]);
            end
        end
        @(negedge Clk);
        DrawX = 10'd207;
        DrawY = 10'd310;
        hit_m = 1'b1;
        @(negedge Clk) hit_m = 1'b0;
        push_probe(1, 207, 310, 1'b0, BLACK, "medium_dead_body");
        push_probe(1, 200, 308, 1'b0, BLACK, "medium_dead_edge");
        while (sb_q.size() > 0) begin
            p = sb_q.pop_front();
            @(negedge Clk);
            DrawX = p.px;
            DrawY = p.py;
            #1;
            got = observe(p.unit);
            checks++;
            if (got !== p.exp) begin
                errors++;
                $display("[TB] FAIL %s: got on/rgb=%0b/%06h, expected %0b/%06h",
                         p.name, got[24], got[23:0], p.exp[24], p.exp[23:0]);
            end
        end
    endtask

    task automatic test_delete();
        probe_t p;
        logic [24:0] got;
        @(negedge Clk);
        DrawX = 10'd82;
        DrawY = 10'd61;
        del_e = 1'b1;
        start_e = 1'b1;
        hit_e = 1'b1;
        @(negedge Clk);
        del_e = 1'b0;
        start_e = 1'b0;
        hit_e = 1'b0;
        push_probe(0, 82, 61, 1'b0, BLACK, "delete_wins_body");
        push_probe(0, 75, 59, 1'b0, BLACK, "delete_wins_edge");
        while (sb_q.size() > 0) begin
            p = sb_q.pop_front();
            @(negedge Clk);
            DrawX = p.px;
            DrawY = p.py;
            #1;
            got = observe(p.unit);
            checks++;
            if (got !== p.exp) begin
                errors++;
                $display("[TB] FAIL %s: got on/rgb=%0b/%06h, expected %0b/%06h",
                         p.name, got[24], got[23:0], p.exp[24], p.exp[23:0]);
            end
        end
        @(negedge Clk) start_e = 1'b1;
        @(negedge Clk) start_e = 1'b0;
        is_playing = 1'b1;
        dir_x = 1'b1;
        dir_y = 1'b0;
        frame_tick();
        @(negedge Clk) start_m = 1'b1;
        @(negedge Clk) start_m = 1'b0;
        push_pos(0, 74, 50, GREEN, "respawn_active");
        push_pos(1, 200, 300, MAGENTA, "medium_respawn_full_hp");
        while (sb_q.size() > 0) begin
            p = sb_q.pop_front();
            @(negedge Clk);
            DrawX = p.px;
            DrawY = p.py;
            #1;
            got = observe(p.unit);
            checks++;
            if (got !== p.exp) begin
                errors++;
                $display("[TB] FAIL %s: got on/rgb=%0b/%06h, expected %0b/%06h",
                         p.name, got[24], got[23:0], p.exp[24], p.exp[23:0]);
            end
        end
    endtask

    task automatic test_frame_held();
        probe_t p;
        logic [24:0] got;
        @(negedge Clk) frame_clk = 1'b1;
        repeat (100) @(negedge Clk);
        frame_clk = 1'b0;
        push_pos(0, 75, 50, GREEN, "held_one_move_easy");
        push_pos(1, 201, 300, MAGENTA, "held_one_move_medium");
        while (sb_q.size() > 0) begin
            p = sb_q.pop_front();
            @(negedge Clk);
            DrawX = p.px;
            DrawY = p.py;
            #1;
            got = observe(p.unit);
            checks++;
            if (got !== p.exp) begin
                errors++;
                $display("[TB] FAIL %s: got on/rgb=%0b/%06h, expected %0b/%06h",
                         p.name, got[24], got[23:0], p.exp[24], p.exp[23:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        probe_t p;
        logic [24:0] got;
        @(negedge Clk);
        DrawX = 10'd208;
        DrawY = 10'd310;
        hit_m = 1'b1;
        repeat (2) @(negedge Clk);
        hit_m = 1'b0;
        push_probe(1, 208, 310, 1'b0, BLACK, "held_hit_twice_kills");
        while (sb_q.size() > 0) begin
            p = sb_q.pop_front();
            @(negedge Clk);
            DrawX = p.px;
            DrawY = p.py;
            #1;
            got = observe(p.unit);
            checks++;
            if (got !== p.exp) begin
                errors++;
                $display("[TB] FAIL %s: got on/rgb=%0b/%06h, expected %0b/%06h",
                         p.name, got[24], got[23:0], p.exp[24], p.exp[23:0]);
            end
        end
        @(negedge Clk) Reset = 1'b0;
        @(negedge Clk) Reset = 1'b1;
        frame_tick();
        push_pos(0, 73, 50, GREEN, "reset_mid_active_easy");
        push_pos(1, 200, 300, MAGENTA, "reset_from_dead_medium");
        while (sb_q.size() > 0) begin
            p = sb_q.pop_front();
            @(negedge Clk);
            DrawX = p.px;
            DrawY = p.py;
            #1;
            got = observe(p.unit);
            checks++;
            if (got !== p.exp) begin
                errors++;
                $display("[TB] FAIL %s: got on/rgb=%0b/%06h, expected %0b/%06h",
                         p.name, got[24], got[23:0], p.exp[24], p.exp[23:0]);
            end
        end
    endtask

    initial begin
        Reset      = 1'b0;
        frame_clk  = 1'b0;
        is_playing = 1'b0;
        dir_x      = 1'b0;
        dir_y      = 1'b0;
        DrawX      = 10'd0;
        DrawY      = 10'd0;
        start_e    = 1'b0;
        start_m    = 1'b0;
        hit_e      = 1'b0;
        hit_m      = 1'b0;
        del_e      = 1'b0;
        del_m      = 1'b0;
        init_x_e   = 10'd73;
        init_y_e   = 10'd50;
        init_x_m   = 10'd200;
        init_y_m   = 10'd300;
        test_reset();
        test_idle_hit();
        test_move();
        test_hit_medium();
        test_delete();
        test_frame_held();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
